// File: rtl/warmboot_pkg.sv
// rtl/warmboot_pkg.sv - state encoding, image constants and counter sizing for the warmboot controller
package warmboot_pkg;

    typedef enum logic [1:0] {
        GUARD = 2'd0,
        IDLE  = 2'd1,
        SETUP = 2'd2,
        BOOT  = 2'd3
    } wb_state_e;

    localparam logic [1:0] IMG0 = 2'd0;
    localparam logic [1:0] IMG1 = 2'd1;
    localparam logic [1:0] IMG2 = 2'd2;
    localparam logic [1:0] IMG3 = 2'd3;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/warmboot_ctrl_if.sv
// rtl/warmboot_ctrl_if.sv - request/status bundle between the requester and the warmboot controller
interface warmboot_ctrl_if;
    logic       req_valid;
    logic [1:0] req_image;
    logic       req_ready;
    logic       abort;
    logic       busy;
    logic       err;

    modport master (
        output req_valid, req_image, abort,
        input  req_ready, busy, err
    );

    modport slave (
        input  req_valid, req_image, abort,
        output req_ready, busy, err
    );
endinterface

// File: rtl/warmboot_ctrl.sv
// rtl/warmboot_ctrl.sv - guarded warmboot sequencer; WARMBOOT_CTRL_PRIM_EN adds an SB_WARMBOOT instance
module warmboot_ctrl #(
    parameter int         GUARD_CYCLES = 4194304,
    parameter int         SETUP_CYCLES = 16,
    parameter logic [3:0] ALLOWED_MASK = 4'b1111
) (
    input  logic           CLK,
    input  logic           RST,
    warmboot_ctrl_if.slave bus,
    output logic           BOOT,
    output logic           S1,
    output logic           S0
);
    import warmboot_pkg::*;

    localparam int GW = cnt_width(GUARD_CYCLES);
    localparam int SW = cnt_width(SETUP_CYCLES);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
    localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);

    wb_state_e     state_q;
    logic [GW-1:0] guard_cnt_q;
    logic [SW-1:0] setup_cnt_q;
    logic          ready_q;
    logic          busy_q;
    logic          err_q;
    logic          boot_q;
    logic [1:0]    img_q;

    // Counters stop at their last value rather than wrapping; BOOT is left only by reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= warmboot_pkg::GUARD;
            guard_cnt_q <= '0;
            setup_cnt_q <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            boot_q      <= 1'b0;
            img_q       <= 2'b00;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                warmboot_pkg::GUARD: begin
                    if (guard_cnt_q == GUARD_LAST) begin
                        state_q <= warmboot_pkg::IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        guard_cnt_q <= guard_cnt_q + 1'b1;
                    end
                end
                warmboot_pkg::IDLE: begin
                    if (bus.req_valid && ready_q) begin
                        if (ALLOWED_MASK[bus.req_image]) begin
                            state_q     <= warmboot_pkg::SETUP;
                            img_q       <= bus.req_image;
                            setup_cnt_q <= '0;
                            ready_q     <= 1'b0;
                            busy_q      <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                warmboot_pkg::SETUP: begin
                    if (bus.abort) begin
                        state_q <= warmboot_pkg::IDLE;
                        img_q   <= 2'b00;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (setup_cnt_q == SETUP_LAST) begin
                        state_q <= warmboot_pkg::BOOT;
                        boot_q  <= 1'b1;
                    end else begin
                        setup_cnt_q <= setup_cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign BOOT          = boot_q;
    assign S1            = img_q[1];
    assign S0            = img_q[0];

`ifdef WARMBOOT_CTRL_PRIM_EN
    SB_WARMBOOT u_warmboot (
        .BOOT (boot_q),
        .S1   (img_q[1]),
        .S0   (img_q[0])
    );
`else
    // The parent instantiates SB_WARMBOOT from BOOT/S1/S0.
`endif

endmodule

// File: tb/tb_warmboot_ctrl.sv
// tb/tb_warmboot_ctrl.sv - scoreboard bench for warmboot_ctrl (GUARD=8, SETUP=4, mask 0111)
module tb_warmboot_ctrl;
    import warmboot_pkg::*;

    typedef struct {
        int         cyc;
        logic [5:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic boot, s1, s0;
    int   cyc;
    int   n_checks = 0;
    int   n_err    = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [5:0] prev = '0;

    warmboot_ctrl_if bus ();

    warmboot_ctrl #(
        .GUARD_CYCLES (8),
        .SETUP_CYCLES (4),
        .ALLOWED_MASK (4'b0111)
    ) dut (
        .CLK  (clk),
        .RST  (rst),
        .bus  (bus),
        .BOOT (boot),
        .S1   (s1),
        .S0   (s0)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Observation tuple: {req_ready, busy, err, BOOT, S1, S0}
    function automatic logic [5:0] obs();
        return {bus.req_ready, bus.busy, bus.err, boot, s1, s0};
    endfunction

    task automatic expect_at(input int c, input logic [5:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] req);
        n_checks++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s got=%b required=%b", name, got, req);
        end
    endtask

    task automatic at_cyc(input int n);
        int k;
        k = 0;
        while (cyc != n && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (cyc != n) begin
            n_checks++;
            n_err++;
            $display("FAIL at_cyc_timeout got=%0d required=%0d", cyc, n);
        end
    endtask

    // Every output change must match the next queued expectation, both value and cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev = '0;
        end else if (obs() !== prev) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_change cyc=%0d got=%b required=no change from %b", cyc, obs(), prev);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.v !== obs()) begin
                    n_err++;
                    $display("FAIL output_change got cyc=%0d val=%b required cyc=%0d val=%b",
                             cyc, obs(), mon_e.cyc, mon_e.v);
                end
            end
            prev = obs();
        end
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_image = IMG0;
        bus.abort     = 1'b0;
        @(posedge clk);
        #1;
        check("reset_outputs", obs(), 6'b000000);

        // Request held through guard: ignored until ready, then boots image 1
        bus.req_valid = 1'b1;
        bus.req_image = IMG1;
        expect_at(8,  6'b100000);
        expect_at(9,  6'b010001);
        expect_at(13, 6'b010101);
        @(posedge clk);
        #1;
        rst = 1'b0;
        at_cyc(15); bus.abort = 1'b1;
        at_cyc(17); bus.abort = 1'b0;
        at_cyc(18); bus.req_valid = 1'b0;

        // Asynchronous reset pulse mid-BOOT
        at_cyc(20);
        expect_at(0, 6'b000000);
        expect_at(8, 6'b100000);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", obs(), 6'b000000);
        #2;
        rst = 1'b0;

        // Disallowed image 3
        expect_at(11, 6'b101000);
        expect_at(12, 6'b100000);
        at_cyc(10); bus.req_valid = 1'b1; bus.req_image = IMG3;
        at_cyc(11); bus.req_valid = 1'b0;

        // Image 2 aborted at setup cycle 2
        expect_at(15, 6'b010010);
        expect_at(18, 6'b100000);
        at_cyc(14); bus.req_valid = 1'b1; bus.req_image = IMG2;
        at_cyc(15); bus.req_valid = 1'b0;
        at_cyc(17); bus.abort = 1'b1;
        at_cyc(18); bus.abort = 1'b0;

        // Image 0 accepted, aborted in its final setup cycle
        expect_at(21, 6'b010000);
        expect_at(25, 6'b100000);
        at_cyc(20); bus.req_valid = 1'b1; bus.req_image = IMG0;
        at_cyc(21); bus.req_valid = 1'b0;
        at_cyc(24); bus.abort = 1'b1;
        at_cyc(25); bus.abort = 1'b0;

        // Abort while idle does nothing
        at_cyc(27); bus.abort = 1'b1;
        at_cyc(29); bus.abort = 1'b0;

        at_cyc(32);
        check("final_idle", obs(), 6'b100000);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_expectations got=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
